// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller: FSM state codes,
// winner codes, the eight winning-line masks and a cell-index decode helper.
package ttt_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_HUMAN_WAIT = 3'd1;
  localparam state_t ST_AI_WAIT    = 3'd2;
  localparam state_t ST_CHECK      = 3'd3;
  localparam state_t ST_GAME_OVER  = 3'd4;

  typedef enum logic [1:0] {
    WINNER_NONE = 2'b00,
    WINNER_X    = 2'b01,
    WINNER_O    = 2'b10,
    WINNER_DRAW = 2'b11
  } winner_e;

  // Bit i of a board is cell i, row-major; entries follow win_line bit order.
  localparam logic [8:0] LINE_MASK [0:7] = '{
    9'h007, 9'h038, 9'h1c0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  localparam logic [3:0] CELL_NONE = 4'd9;

  function automatic logic [8:0] cell_mask(input logic [3:0] idx);
    return (idx <= 4'd8) ? (9'd1 << idx) : 9'd0;
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Move handshake, AI move and board/result signals of the game controller.
// Score counters exist only when TTT_SCORE_EN is defined.
interface ttt_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic       start;
  logic       human_first;
  logic       move_valid;
  logic [3:0] move_idx;
  logic       move_ready;
  logic       move_illegal;
  logic [3:0] ai_move;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic       ai_turn;
  logic       game_over;
  logic [1:0] winner;
  logic [7:0] win_line;
`ifdef TTT_SCORE_EN
  logic [SCORE_W-1:0] score_x;
  logic [SCORE_W-1:0] score_o;
  logic [SCORE_W-1:0] score_draw;
`else
  localparam int unused_score_w = SCORE_W;
`endif

  modport master (
    output start, human_first, move_valid, move_idx, ai_move,
    input  move_ready, move_illegal, board_x, board_o, ai_turn, game_over,
           winner, win_line
`ifdef TTT_SCORE_EN
           , score_x, score_o, score_draw
`endif
  );

  modport slave (
    input  start, human_first, move_valid, move_idx, ai_move,
    output move_ready, move_illegal, board_x, board_o, ai_turn, game_over,
           winner, win_line
`ifdef TTT_SCORE_EN
           , score_x, score_o, score_draw
`endif
  );

endinterface

// File: rtl/ttt_win_check.sv
// Combinational line detector: flags every winning line fully occupied on one board.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [8:0] board,
  output logic [7:0] line_hit,
  output logic       any_hit
);

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    line_hit = '0;
    for (int i = 0; i < 8; i++) begin
      line_hit[i] = ((board & LINE_MASK[i]) == LINE_MASK[i]);
    end
  end

  assign any_hit = |line_hit;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: human X vs external AI O, authoritative board, win/draw detection.
// Optional TTT_SCORE_EN adds saturating per-result score counters cleared only by rst_n.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int AI_LATENCY = 2,
  parameter int SCORE_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ttt_game_ctrl_if.slave bus
);

  localparam int WAIT_W = (AI_LATENCY > 1) ? $clog2(AI_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(AI_LATENCY - 1);

  state_t            state;
  logic [8:0]        board_x;
  logic [8:0]        board_o;
  winner_e           winner;
  logic [7:0]        win_line;
  logic              last_ai;
  logic              move_illegal;
  logic [WAIT_W-1:0] wait_cnt;

  logic [8:0] occupied;
  logic       board_full;
  logic       human_legal;
  logic       ai_legal;
  logic [3:0] lowest_empty;
  logic [3:0] ai_cell;
  logic [7:0] x_lines;
  logic [7:0] o_lines;
  logic       x_win;
  logic       o_win;
  logic       game_ends;

  ttt_win_check u_check_x (.board(board_x), .line_hit(x_lines), .any_hit(x_win));
  ttt_win_check u_check_o (.board(board_o), .line_hit(o_lines), .any_hit(o_win));

  assign occupied    = board_x | board_o;
  assign board_full  = &occupied;
  assign human_legal = (bus.move_idx <= 4'd8) && ((cell_mask(bus.move_idx) & occupied) == 9'd0);
  assign ai_legal    = (bus.ai_move <= 4'd8) && ((cell_mask(bus.ai_move) & occupied) == 9'd0);
  assign ai_cell     = ai_legal ? bus.ai_move : lowest_empty;
  assign game_ends   = (state == ST_CHECK) && !bus.start && (x_win || o_win || board_full);

  // Descending scan so the lowest-index empty cell is the last (winning) assignment.
  always_comb begin
    lowest_empty = CELL_NONE;
    for (int i = 8; i >= 0; i--) begin
      if (!occupied[i]) lowest_empty = 4'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      board_x      <= '0;
      board_o      <= '0;
      winner       <= WINNER_NONE;
      win_line     <= '0;
      last_ai      <= 1'b0;
      move_illegal <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      move_illegal <= 1'b0;
      if (bus.start) begin
        board_x  <= '0;
        board_o  <= '0;
        winner   <= WINNER_NONE;
        win_line <= '0;
        last_ai  <= 1'b0;
        if (bus.human_first) begin
          state <= ST_HUMAN_WAIT;
        end else begin
          state    <= ST_AI_WAIT;
          wait_cnt <= WAIT_LOAD;
        end
      end else begin
        case (state)
          ST_HUMAN_WAIT: begin
            if (bus.move_valid) begin
              if (human_legal) begin
                board_x <= board_x | cell_mask(bus.move_idx);
                last_ai <= 1'b0;
                state   <= ST_CHECK;
              end else begin
                move_illegal <= 1'b1;
              end
            end
          end
          ST_AI_WAIT: begin
            if (wait_cnt == '0) begin
              board_o <= board_o | cell_mask(ai_cell);
              last_ai <= 1'b1;
              state   <= ST_CHECK;
            end else begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end
          ST_CHECK: begin
            if (x_win) begin
              winner   <= WINNER_X;
              win_line <= x_lines;
              state    <= ST_GAME_OVER;
            end else if (o_win) begin
              winner   <= WINNER_O;
              win_line <= o_lines;
              state    <= ST_GAME_OVER;
            end else if (board_full) begin
              winner   <= WINNER_DRAW;
              win_line <= '0;
              state    <= ST_GAME_OVER;
            end else if (last_ai) begin
              state <= ST_HUMAN_WAIT;
            end else begin
              state    <= ST_AI_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

`ifdef TTT_SCORE_EN
  logic [SCORE_W-1:0] score_x;
  logic [SCORE_W-1:0] score_o;
  logic [SCORE_W-1:0] score_draw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_x    <= '0;
      score_o    <= '0;
      score_draw <= '0;
    end else if (game_ends) begin
      if (x_win) begin
        if (score_x != '1) score_x <= score_x + SCORE_W'(1);
      end else if (o_win) begin
        if (score_o != '1) score_o <= score_o + SCORE_W'(1);
      end else begin
        if (score_draw != '1) score_draw <= score_draw + SCORE_W'(1);
      end
    end
  end

  assign bus.score_x    = score_x;
  assign bus.score_o    = score_o;
  assign bus.score_draw = score_draw;
`else
  localparam int unused_score_w = SCORE_W;
  logic unused_game_ends;
  assign unused_game_ends = game_ends;
`endif

  assign bus.move_ready   = (state == ST_HUMAN_WAIT);
  assign bus.ai_turn      = (state == ST_AI_WAIT);
  assign bus.game_over    = (state == ST_GAME_OVER);
  assign bus.move_illegal = move_illegal;
  assign bus.board_x      = board_x;
  assign bus.board_o      = board_o;
  assign bus.winner       = winner;
  assign bus.win_line     = win_line;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: scripted games against a stub AI, with a
// scoreboard of expected board/result snapshots. Score checks compile only with TTT_SCORE_EN.
module tb_ttt_game_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ttt_game_ctrl_if #(.SCORE_W(8)) bus ();

  ttt_game_ctrl #(.AI_LATENCY(2), .SCORE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Snapshot vector: {board_x, board_o, winner, win_line}
  typedef struct {
    string       name;
    logic [27:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_sx = 0;
  int   exp_so = 0;
  int   exp_sd = 0;

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.move_ready === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL wait_ready: move_ready still %b after 40 cycles, required 1", bus.move_ready);
  endtask

  task automatic wait_over();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.game_over === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL wait_over: game_over still %b after 40 cycles, required 1", bus.game_over);
  endtask

  task automatic do_start(input logic hf);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.human_first = hf;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic human_move(input logic [3:0] idx, input logic [3:0] ai_next);
    wait_ready();
    bus.ai_move    = ai_next;
    bus.move_valid = 1'b1;
    bus.move_idx   = idx;
    @(negedge clk);
    bus.move_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.move_ready, bus.move_illegal, bus.ai_turn, bus.game_over} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {bus.move_ready, bus.move_illegal, bus.ai_turn, bus.game_over});
    end
    checks++;
    if ({bus.board_x, bus.board_o, bus.winner, bus.win_line} !== 28'h0) begin
      errors++;
      $display("FAIL reset_board: got %h, required 0000000", {bus.board_x, bus.board_o, bus.winner, bus.win_line});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_human_win();
    exp_t e;
    do_start(1'b1);
    checks++;
    if (bus.move_ready !== 1'b1 || bus.board_x !== 9'h0) begin
      errors++;
      $display("FAIL start_human: move_ready=%b board_x=%h, required 1/000", bus.move_ready, bus.board_x);
    end
    human_move(4'd0, 4'd3);
    human_move(4'd1, 4'd4);
    wait_ready();
    exp_q.push_back('{"x_row0_win", {9'h007, 9'h018, 2'b01, 8'h01}});
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd2;
    @(negedge clk);
    bus.move_valid = 1'b0;
    checks++;
    if (bus.board_x !== 9'h007 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL latency_1: board_x=%h game_over=%b, required 007/0", bus.board_x, bus.game_over);
    end
    @(negedge clk);
    checks++;
    if (bus.game_over !== 1'b1) begin
      errors++;
      $display("FAIL latency_2: game_over=%b, required 1", bus.game_over);
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus.board_x, bus.board_o, bus.winner, bus.win_line} !== e.v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", e.name, {bus.board_x, bus.board_o, bus.winner, bus.win_line}, e.v);
    end
    exp_sx++;
  endtask

  task automatic test_game_over_hold();
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd8;
    repeat (2) @(negedge clk);
    bus.move_valid = 1'b0;
    checks++;
    if ({bus.move_ready, bus.move_illegal, bus.game_over} !== 3'b001 ||
        {bus.board_x, bus.board_o, bus.winner, bus.win_line} !== {9'h007, 9'h018, 2'b01, 8'h01}) begin
      errors++;
      $display("FAIL game_over_hold: flags=%b snap=%h, required 001/%h", {bus.move_ready, bus.move_illegal, bus.game_over},
               {bus.board_x, bus.board_o, bus.winner, bus.win_line}, {9'h007, 9'h018, 2'b01, 8'h01});
    end
  endtask

  task automatic test_ai_first();
    bus.ai_move = 4'd4;
    do_start(1'b0);
    checks++;
    if (bus.ai_turn !== 1'b1 || bus.board_o !== 9'h0 || bus.board_x !== 9'h0) begin
      errors++;
      $display("FAIL ai_entry: ai_turn=%b board_o=%h board_x=%h, required 1/000/000", bus.ai_turn, bus.board_o, bus.board_x);
    end
    @(negedge clk);
    checks++;
    if (bus.board_o !== 9'h0) begin
      errors++;
      $display("FAIL ai_early: board_o=%h, required 000", bus.board_o);
    end
    @(negedge clk);
    checks++;
    if (bus.board_o !== 9'h010 || bus.ai_turn !== 1'b0) begin
      errors++;
      $display("FAIL ai_commit: board_o=%h ai_turn=%b, required 010/0", bus.board_o, bus.ai_turn);
    end
    @(negedge clk);
    checks++;
    if (bus.move_ready !== 1'b1) begin
      errors++;
      $display("FAIL ai_then_human: move_ready=%b, required 1", bus.move_ready);
    end
  endtask

  task automatic test_illegal();
    do_start(1'b1);
    human_move(4'd4, 4'd0);
    wait_ready();
    checks++;
    if (bus.board_x !== 9'h010 || bus.board_o !== 9'h001) begin
      errors++;
      $display("FAIL illegal_setup: board_x=%h board_o=%h, required 010/001", bus.board_x, bus.board_o);
    end
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd4;
    @(negedge clk);
    checks++;
    if (bus.move_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_occupied: move_illegal=%b, required 1", bus.move_illegal);
    end
    bus.move_idx = 4'd11;
    @(negedge clk);
    bus.move_valid = 1'b0;
    checks++;
    if (bus.move_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_range: move_illegal=%b, required 1", bus.move_illegal);
    end
    @(negedge clk);
    checks++;
    if (bus.move_illegal !== 1'b0 || bus.move_ready !== 1'b1 ||
        bus.board_x !== 9'h010 || bus.board_o !== 9'h001) begin
      errors++;
      $display("FAIL illegal_after: illegal=%b ready=%b board_x=%h board_o=%h, required 0/1/010/001",
               bus.move_illegal, bus.move_ready, bus.board_x, bus.board_o);
    end
  endtask

  task automatic test_ai_fallback();
    exp_t e;
    do_start(1'b1);
    human_move(4'd0, 4'd1);
    human_move(4'd2, 4'd3);
    exp_q.push_back('{"ai_occupied_fallback", {9'h015, 9'h02a, 2'b00, 8'h00}});
    human_move(4'd4, 4'd4);
    wait_ready();
    e = exp_q.pop_front();
    checks++;
    if ({bus.board_x, bus.board_o, bus.winner, bus.win_line} !== e.v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", e.name, {bus.board_x, bus.board_o, bus.winner, bus.win_line}, e.v);
    end
    exp_q.push_back('{"ai_range_fallback", {9'h095, 9'h06a, 2'b00, 8'h00}});
    human_move(4'd7, 4'd15);
    wait_ready();
    e = exp_q.pop_front();
    checks++;
    if ({bus.board_x, bus.board_o, bus.winner, bus.win_line} !== e.v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", e.name, {bus.board_x, bus.board_o, bus.winner, bus.win_line}, e.v);
    end
    exp_q.push_back('{"x_diag_win", {9'h195, 9'h06a, 2'b01, 8'h40}});
    human_move(4'd8, 4'd0);
    wait_over();
    e = exp_q.pop_front();
    checks++;
    if ({bus.board_x, bus.board_o, bus.winner, bus.win_line} !== e.v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", e.name, {bus.board_x, bus.board_o, bus.winner, bus.win_line}, e.v);
    end
    exp_sx++;
  endtask

  task automatic test_draw();
    exp_t e;
    do_start(1'b1);
    exp_q.push_back('{"draw", {9'h0e5, 9'h11a, 2'b11, 8'h00}});
    human_move(4'd0, 4'd1);
    human_move(4'd2, 4'd3);
    human_move(4'd5, 4'd4);
    human_move(4'd6, 4'd8);
    human_move(4'd7, 4'd0);
    wait_over();
    e = exp_q.pop_front();
    checks++;
    if ({bus.board_x, bus.board_o, bus.winner, bus.win_line} !== e.v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", e.name, {bus.board_x, bus.board_o, bus.winner, bus.win_line}, e.v);
    end
    exp_sd++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus.ai_move = 4'd0;
    do_start(1'b0);
    exp_q.push_back('{"o_row0_win", {9'h018, 9'h007, 2'b10, 8'h01}});
    human_move(4'd3, 4'd1);
    human_move(4'd4, 4'd2);
    wait_over();
    e = exp_q.pop_front();
    checks++;
    if ({bus.board_x, bus.board_o, bus.winner, bus.win_line} !== e.v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", e.name, {bus.board_x, bus.board_o, bus.winner, bus.win_line}, e.v);
    end
    exp_so++;
  endtask

  task automatic test_scores();
`ifdef TTT_SCORE_EN
    checks++;
    if (bus.score_x !== 8'(exp_sx) || bus.score_o !== 8'(exp_so) || bus.score_draw !== 8'(exp_sd)) begin
      errors++;
      $display("FAIL scores: got x=%0d o=%0d d=%0d, required x=%0d o=%0d d=%0d",
               bus.score_x, bus.score_o, bus.score_draw, exp_sx, exp_so, exp_sd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bus.ai_move = 4'd4;
    do_start(1'b1);
    human_move(4'd0, 4'd4);
    @(negedge clk);
    checks++;
    if (bus.ai_turn !== 1'b1) begin
      errors++;
      $display("FAIL mid_ai_wait: ai_turn=%b, required 1", bus.ai_turn);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.move_ready, bus.ai_turn, bus.game_over} !== 3'b000 ||
        {bus.board_x, bus.board_o, bus.winner, bus.win_line} !== 28'h0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b snap=%h, required 000/0000000", {bus.move_ready, bus.ai_turn, bus.game_over},
               {bus.board_x, bus.board_o, bus.winner, bus.win_line});
    end
    exp_sx = 0; exp_so = 0; exp_sd = 0;
    test_scores();
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd0;
    @(negedge clk);
    bus.move_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.board_x !== 9'h0 || bus.move_ready !== 1'b0 || bus.move_illegal !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: board_x=%h ready=%b illegal=%b, required 000/0/0", bus.board_x, bus.move_ready, bus.move_illegal);
    end
    do_start(1'b1);
    human_move(4'd0, 4'd4);
    wait_ready();
    checks++;
    if (bus.board_x !== 9'h001 || bus.board_o !== 9'h010) begin
      errors++;
      $display("FAIL restart_setup: board_x=%h board_o=%h, required 001/010", bus.board_x, bus.board_o);
    end
    bus.start       = 1'b1;
    bus.human_first = 1'b0;
    bus.move_valid  = 1'b1;
    bus.move_idx    = 4'd8;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.move_valid = 1'b0;
    checks++;
    if (bus.board_x !== 9'h0 || bus.board_o !== 9'h0 || bus.ai_turn !== 1'b1 || bus.move_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_priority: board_x=%h board_o=%h ai_turn=%b ready=%b, required 000/000/1/0",
               bus.board_x, bus.board_o, bus.ai_turn, bus.move_ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start       = 1'b0;
    bus.human_first = 1'b0;
    bus.move_valid  = 1'b0;
    bus.move_idx    = 4'd0;
    bus.ai_move     = 4'd0;
    test_reset();
    test_human_win();
    test_game_over_hold();
    test_ai_first();
    test_illegal();
    test_ai_fallback();
    test_draw();
    test_back_to_back();
    test_scores();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
